// File: rtl/crack_pkg.sv
// Shared types and seven-segment helpers for the ARC4 key-search scheduler.
package crack_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      RUN,
      ABORT,
      DONE
   } crack_state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Active-low segments, bit 6 = segment g, bit 0 = segment a.
   function automatic logic [6:0] seg_lut(input logic [3:0] d);
      logic [6:0] s;
      s = SEG_BLANK;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/crack_sched_if.sv
// Bus between the scheduler (master) and the array of crack cores (slave).
interface crack_sched_if #(
   parameter int NUM_CORES = 2,
   parameter int KEY_WIDTH = 24
) ();

   logic [NUM_CORES-1:0]           core_en;
   logic                           core_abort;
   logic [NUM_CORES*KEY_WIDTH-1:0] core_base;
   logic [KEY_WIDTH-1:0]           core_stride;
   logic [NUM_CORES-1:0]           core_rdy;
   logic [NUM_CORES-1:0]           core_key_valid;
   logic [NUM_CORES*KEY_WIDTH-1:0] core_key;

   modport master (
      output core_en, core_abort, core_base, core_stride,
      input  core_rdy, core_key_valid, core_key
   );

   modport slave (
      input  core_en, core_abort, core_base, core_stride,
      output core_rdy, core_key_valid, core_key
   );

endinterface

// File: rtl/crack_sched_hex7seg.sv
// One seven-segment digit: blank when hidden, dash when no valid key, else hex glyph.
module hex7seg
   import crack_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       show,
   input  logic       valid,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (show) begin
         seg = valid ? seg_lut(digit) : SEG_DASH;
      end
   end

endmodule

// File: rtl/crack_sched.sv
// Interleaved launch / first-valid-wins collection / abort over NUM_CORES crack cores.
// Optional watchdog enabled by defining CRACK_SCHED_TIMEOUT_EN.
module crack_sched
   import crack_pkg::*;
#(
   parameter int NUM_CORES = 2,
   parameter int KEY_WIDTH = 24,
   parameter int TIMEOUT_W = 32,
   localparam int NUM_DIGITS = KEY_WIDTH / 4,
   localparam int WIN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [KEY_WIDTH-1:0]    key,
   output logic                    key_valid,
   output logic [WIN_W-1:0]        winner,
   output logic                    timed_out,
   output logic [NUM_DIGITS*7-1:0] hex,
   crack_sched_if.master           cif
);

   crack_state_t state_q, state_d;
   logic [KEY_WIDTH-1:0]    key_q, key_d;
   logic                    key_valid_q, key_valid_d;
   logic [WIN_W-1:0]        winner_q, winner_d;
   logic [NUM_CORES-1:0]    started_q, started_d;
   logic [NUM_DIGITS*7-1:0] hex_q, hex_d;

   logic                    found;
   logic [WIN_W-1:0]        win_idx;
   logic [KEY_WIDTH-1:0]    win_key;
   logic                    timeout_hit;

`ifdef CRACK_SCHED_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                 timed_out_q, timed_out_d;
`endif

   // Lowest index wins: scan downwards so the last hit is the smallest index.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      win_key = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (cif.core_rdy[i] && cif.core_key_valid[i]) begin
            found   = 1'b1;
            win_idx = WIN_W'(i);
            win_key = cif.core_key[i*KEY_WIDTH +: KEY_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      winner_d    = winner_q;
      started_d   = started_q;
      timeout_hit = 1'b0;
`ifdef CRACK_SCHED_TIMEOUT_EN
      cnt_d       = cnt_q;
      timed_out_d = timed_out_q;
      timeout_hit = (cnt_q == '1);
      if ((state_q == WAIT_BUSY || state_q == RUN) && !timeout_hit) begin
         cnt_d = cnt_q + 1'b1;
      end
`endif
      case (state_q)
         IDLE: begin
            if (start && (&cif.core_rdy)) state_d = LAUNCH;
         end
         LAUNCH: begin
            key_d       = '0;
            key_valid_d = 1'b0;
            winner_d    = '0;
            started_d   = '0;
`ifdef CRACK_SCHED_TIMEOUT_EN
            cnt_d       = '0;
            timed_out_d = 1'b0;
`endif
            state_d     = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // A core that dropped rdy and already raised it again is treated as finished in RUN.
            started_d = started_q | ~cif.core_rdy;
            if (timeout_hit) begin
`ifdef CRACK_SCHED_TIMEOUT_EN
               timed_out_d = 1'b1;
`endif
               state_d = ABORT;
            end else if (&started_d) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (found) begin
               key_d       = win_key;
               winner_d    = win_idx;
               key_valid_d = 1'b1;
               state_d     = ABORT;
            end else if (&cif.core_rdy) begin
               state_d = DONE;
            end else if (timeout_hit) begin
`ifdef CRACK_SCHED_TIMEOUT_EN
               timed_out_d = 1'b1;
`endif
               state_d = ABORT;
            end
         end
         ABORT: state_d = DONE;
         DONE: begin
            if (start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      hex7seg u_hex7seg (
         .digit (key_d[g*4 +: 4]),
         .show  (state_d == DONE),
         .valid (key_valid_d),
         .seg   (hex_d[g*7 +: 7])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         winner_q    <= '0;
         started_q   <= '0;
         hex_q       <= '1;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         winner_q    <= winner_d;
         started_q   <= started_d;
         hex_q       <= hex_d;
      end
   end

`ifdef CRACK_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         timed_out_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         timed_out_q <= timed_out_d;
      end
   end
   assign timed_out = timed_out_q;
`else
   assign timed_out = 1'b0;
`endif

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_base
      assign cif.core_base[c*KEY_WIDTH +: KEY_WIDTH] = KEY_WIDTH'(c);
   end

   assign cif.core_stride = KEY_WIDTH'(NUM_CORES);
   assign cif.core_en     = {NUM_CORES{state_q == LAUNCH}};
   assign cif.core_abort  = (state_q == ABORT);

   assign busy      = (state_q == LAUNCH) || (state_q == WAIT_BUSY) ||
                      (state_q == RUN) || (state_q == ABORT);
   assign done      = (state_q == DONE);
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign winner    = winner_q;
   assign hex       = hex_q;

endmodule

// File: tb/tb_crack_sched.sv
// Directed bench for crack_sched: a 2-core and a 4-core instance driven with hand-computed vectors.
module tb_crack_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int numChecks = 0;
   int numFails  = 0;

   logic        rst2, start2, busy2, done2, kv2, to2;
   logic [23:0] key2;
   logic [0:0]  win2;
   logic [41:0] hex2;

   logic        rst4, start4, busy4, done4, kv4, to4;
   logic [23:0] key4;
   logic [1:0]  win4;
   logic [41:0] hex4;

   crack_sched_if #(.NUM_CORES(2), .KEY_WIDTH(24)) if2 ();
   crack_sched_if #(.NUM_CORES(4), .KEY_WIDTH(24)) if4 ();

   crack_sched #(.NUM_CORES(2), .KEY_WIDTH(24), .TIMEOUT_W(4)) u_dut2 (
      .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
      .key(key2), .key_valid(kv2), .winner(win2), .timed_out(to2),
      .hex(hex2), .cif(if2.master)
   );

   crack_sched #(.NUM_CORES(4), .KEY_WIDTH(24), .TIMEOUT_W(4)) u_dut4 (
      .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .done(done4),
      .key(key4), .key_valid(kv4), .winner(win4), .timed_out(to4),
      .hex(hex4), .cif(if4.master)
   );

   localparam logic [41:0] HEX_BLANK = {6{7'b1111111}};
   localparam logic [41:0] HEX_DASH  = {6{7'b0111111}};
   localparam logic [41:0] HEX_A3B1  = {7'b1000000, 7'b1000000, 7'b0001000,
                                        7'b0110000, 7'b0000011, 7'b1111001};

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic [1:0] rdy, input logic [1:0] kv, input logic [47:0] keys);
      start2             = st;
      if2.core_rdy       = rdy;
      if2.core_key_valid = kv;
      if2.core_key       = keys;
   endtask

   task automatic applyStimulusQuad(input logic st, input logic [3:0] rdy, input logic [3:0] kv, input logic [95:0] keys);
      start4             = st;
      if4.core_rdy       = rdy;
      if4.core_key_valid = kv;
      if4.core_key       = keys;
   endtask

   initial begin
      int aborts;
      int cycles;
      rst2 = 1'b1;
      rst4 = 1'b1;
      applyStimulus(1'b0, 2'b11, 2'b00, '0);
      applyStimulusQuad(1'b0, 4'b1111, 4'b0000, '0);
      tick();
      tick();

      // Reset state
      checkOutput("rst_busy", busy2, 0);
      checkOutput("rst_done", done2, 0);
      checkOutput("rst_key", key2, 0);
      checkOutput("rst_kv", kv2, 0);
      checkOutput("rst_winner", win2, 0);
      checkOutput("rst_timed_out", to2, 0);
      checkOutput("rst_core_en", if2.core_en, 0);
      checkOutput("rst_abort", if2.core_abort, 0);
      checkOutput("rst_hex", hex2, HEX_BLANK);
      for (int i = 0; i < 2; i++) checkOutput("base2", if2.core_base[i*24 +: 24], i);
      checkOutput("stride2", if2.core_stride, 2);
      for (int i = 0; i < 4; i++) checkOutput("base4", if4.core_base[i*24 +: 24], i);
      checkOutput("stride4", if4.core_stride, 4);

      rst2 = 1'b0;
      rst4 = 1'b0;
      tick();

      // Core 1 returns a valid key
      applyStimulus(1'b1, 2'b11, 2'b00, '0);
      tick();
      checkOutput("t1_core_en", if2.core_en, 2'b11);
      checkOutput("t1_busy", busy2, 1);
      applyStimulus(1'b0, 2'b00, 2'b00, '0);
      tick();
      checkOutput("t1_en_pulse", if2.core_en, 0);
      tick();
      applyStimulus(1'b0, 2'b10, 2'b10, {24'h00A3B1, 24'h000000});
      tick();
      checkOutput("t1_abort", if2.core_abort, 1);
      checkOutput("t1_not_done", done2, 0);
      applyStimulus(1'b0, 2'b11, 2'b00, '0);
      tick();
      checkOutput("t1_abort_pulse", if2.core_abort, 0);
      checkOutput("t1_done", done2, 1);
      checkOutput("t1_key", key2, 24'h00A3B1);
      checkOutput("t1_kv", kv2, 1);
      checkOutput("t1_winner", win2, 1);
      checkOutput("t1_busy_low", busy2, 0);
      checkOutput("t1_hex", hex2, HEX_A3B1);

      // Both cores finish without a key
      applyStimulus(1'b1, 2'b11, 2'b00, '0);
      tick();
      checkOutput("t2_idle_done", done2, 0);
      checkOutput("t2_idle_hex", hex2, HEX_BLANK);
      tick();
      checkOutput("t2_core_en", if2.core_en, 2'b11);
      applyStimulus(1'b0, 2'b00, 2'b00, '0);
      tick();
      tick();
      applyStimulus(1'b0, 2'b01, 2'b00, '0);
      tick();
      checkOutput("t2_still_busy", busy2, 1);
      applyStimulus(1'b0, 2'b11, 2'b00, '0);
      tick();
      checkOutput("t2_no_abort", if2.core_abort, 0);
      checkOutput("t2_done", done2, 1);
      checkOutput("t2_kv", kv2, 0);
      checkOutput("t2_key", key2, 0);
      checkOutput("t2_hex", hex2, HEX_DASH);

      // Start held while core 1 is not ready
      applyStimulus(1'b1, 2'b01, 2'b00, '0);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t3_no_en", if2.core_en, 0);
         checkOutput("t3_not_busy", busy2, 0);
      end
      applyStimulus(1'b1, 2'b11, 2'b00, '0);
      tick();
      checkOutput("t3_core_en", if2.core_en, 2'b11);

      // Reset during RUN
      applyStimulus(1'b0, 2'b00, 2'b00, '0);
      tick();
      tick();
      checkOutput("t4_running", busy2, 1);
      rst2 = 1'b1;
      tick();
      checkOutput("t4_busy", busy2, 0);
      checkOutput("t4_core_en", if2.core_en, 0);
      checkOutput("t4_hex", hex2, HEX_BLANK);
      rst2 = 1'b0;
      applyStimulus(1'b1, 2'b11, 2'b00, '0);
      tick();
      checkOutput("t4_relaunch", if2.core_en, 2'b11);

      // Cores never finish: watchdog with TIMEOUT_W=4
      applyStimulus(1'b0, 2'b00, 2'b00, '0);
      aborts = 0;
      cycles = 0;
      while (cycles < 30 && !done2) begin
         tick();
         cycles++;
         if (if2.core_abort) aborts++;
      end
`ifdef CRACK_SCHED_TIMEOUT_EN
      checkOutput("t5_abort_count", aborts, 1);
      checkOutput("t5_done", done2, 1);
      checkOutput("t5_timed_out", to2, 1);
      checkOutput("t5_kv", kv2, 0);
      checkOutput("t5_hex", hex2, HEX_DASH);
`else
      checkOutput("t5_abort_count", aborts, 0);
      checkOutput("t5_busy", busy2, 1);
      checkOutput("t5_done", done2, 0);
      checkOutput("t5_timed_out", to2, 0);
`endif

      // Cores 0 and 3 valid together
      applyStimulusQuad(1'b1, 4'b1111, 4'b0000, '0);
      tick();
      checkOutput("t6_core_en", if4.core_en, 4'b1111);
      applyStimulusQuad(1'b0, 4'b0000, 4'b0000, '0);
      tick();
      tick();
      applyStimulusQuad(1'b0, 4'b1001, 4'b1001,
                        {24'h654321, 24'h0, 24'h0, 24'h123456});
      tick();
      checkOutput("t6_abort", if4.core_abort, 1);
      applyStimulusQuad(1'b0, 4'b1111, 4'b0000, '0);
      tick();
      checkOutput("t6_done", done4, 1);
      checkOutput("t6_winner", win4, 0);
      checkOutput("t6_key", key4, 24'h123456);
      checkOutput("t6_kv", kv4, 1);
      checkOutput("t6_timed_out", to4, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
